rca_shift_add_mul_8b: RTL and testbench
=======================================

Name: rca_shift_add_mul_8b

Overview:
Sequential 8x8 unsigned shift-and-add multiplier. It is the direct consumer of the 8-bit ripple-carry adder `rca_8b_top`: it instantiates one `rca_8b_top` and calls it once per iteration to add the multiplicand into the partial product. The block sits between the operand source and the result sink, with valid/ready handshakes on both sides. It produces one 16-bit product every 8 compute cycles plus handshake overhead.

Parameters:
WIDTH, 8, operand width. Fixed at 8 because the adder is the 8-bit `rca_8b_top`. Any other value is a configuration error and must be flagged at elaboration.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair on x/y is valid
in_ready  output  1  block can accept an operand pair
x  input  8  multiplicand, unsigned
y  input  8  multiplier, unsigned
out_valid  output  1  product is valid
out_ready  input  1  sink accepts the product
product  output  16  x*y, unsigned

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; product=16'h0000.
  - Internal registers cleared: M, A, Q, C, count.
  - Reset has priority over every other event in the same cycle.
- States: IDLE, CALC, DONE.
- Output decodes:
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On an edge with in_valid=1: M<=x, Q<=y, A<=0, C<=0, count<=0, then go to CALC.
  - If in_valid=0, stay in IDLE.
- CALC, one iteration per edge:
  - Adder inputs: x=A, y=(Q[0] ? M : 8'h00), carry_in=0.
  - Adder result gives {C',S}.
  - Register update: {C,A,Q} <= {1'b0, C', S, Q[7:1]}, i.e. a 17-bit right shift of {C',S,Q}.
  - count <= count+1.
  - When the iteration with count==7 completes, go to DONE. count is 3 bits and wraps to 0.
- DONE:
  - product = {A,Q}, held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE; product keeps its value until the next DONE.
- Latency and throughput:
  - Operand accepted at edge E0; out_valid is first high after edge E8.
  - Minimum issue interval is 10 cycles: 1 accept, 8 CALC, at least 1 DONE, with the return to IDLE on the DONE-handshake edge.
- in_valid is ignored outside IDLE. x/y are sampled only on the accept edge, so later changes to x/y have no effect on a running operation.
- Width rules:
  - The product is never truncated; the maximum is 255*255 = 16'hFE01.
  - The adder carry_out is captured every iteration and is never dropped.
- No back-to-back overlap: an operand presented while in DONE waits until IDLE.
- Reset mid-CALC or mid-DONE: abort, apply the reset values above, and produce no output for the aborted operation.
- The adder is purely combinational; there are no registers inside the `rca_8b_top` instance.

Test Plan:
- Reset, then x=0, y=0 -> out_valid rises exactly 8 cycles after acceptance, product=16'h0000, in_ready=0 throughout CALC/DONE.
- x=8'hFF, y=8'hFF with out_ready=1 -> product=16'hFE01 (carry path exercised every iteration); in_ready returns to 1 on the cycle after the handshake.
- Sequence (1,255), (16,16), (128,2), (3,5) -> products 16'h00FF, 16'h0100, 16'h0100, 16'h000F.
- Back-pressure: x=8'h0D, y=8'h0B, out_ready held 0 for 5 cycles after out_valid -> product=16'h008F held stable, in_valid pulses ignored, accepted on out_ready=1.
- Reset asserted on the 4th CALC cycle of x=8'hAA, y=8'h55 -> next cycle in_ready=1, out_valid=0, product=0. A new op x=8'h02, y=8'h03 then yields 16'h0006.
- x/y changed every cycle during CALC after accepting x=8'h07, y=8'h09 -> product=16'h003F, unaffected.

Source files
------------

// File: rtl/rca_shift_add_mul_8b.sv
// 8x8 unsigned shift-and-add multiplier built around a ripple-carry adder.
// One partial-product add per CALC cycle, valid/ready on both sides.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_8b_top (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out
);
  logic [8:0] cy;

  assign cy[0] = carry_in;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    fa_cell u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (cy[i]),
      .s  (sum[i]),
      .co (cy[i+1])
    );
  end

  assign carry_out = cy[8];
endmodule

module rca_shift_add_mul_8b #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  if (WIDTH != 8) begin : g_width_chk
    $error("rca_shift_add_mul_8b: WIDTH must be 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  m;
  logic [7:0]  a;
  logic [7:0]  q;
  logic        c;
  logic [2:0]  count;

  logic [7:0]  add_y;
  logic [7:0]  add_s;
  logic        add_co;
  logic [15:0] shifted;
  logic        unused_c;

  assign add_y = q[0] ? m : 8'h00;

  rca_8b_top u_add (
    .x         (a),
    .y         (add_y),
    .carry_in  (1'b0),
    .sum       (add_s),
    .carry_out (add_co)
  );

  // {C',S,Q} shifted right by one; the dropped LSB is the consumed
  // multiplier bit, and the carry lands in A's MSB so it is never lost.
  assign shifted  = {add_co, add_s, q[7:1]};
  assign unused_c = c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= 16'h0000;
      m         <= 8'h00;
      a         <= 8'h00;
      q         <= 8'h00;
      c         <= 1'b0;
      count     <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            m        <= x;
            q        <= y;
            a        <= 8'h00;
            c        <= 1'b0;
            count    <= 3'd0;
            state    <= CALC;
            in_ready <= 1'b0;
          end
        end
        CALC: begin
          a     <= shifted[15:8];
          q     <= shifted[7:0];
          c     <= 1'b0;
          count <= count + 3'd1;
          if (count == 3'd7) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= shifted;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_shift_add_mul_8b.sv
// Bench for rca_shift_add_mul_8b: directed cases plus random operands
// checked against plain x*y.

module tb_rca_shift_add_mul_8b;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rca_shift_add_mul_8b #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] p,
                                          input logic [7:0] r);
    int unsigned prod;
    prod = int'(p) * int'(r);
    return prod[15:0];
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int stall, input bit scramble);
    logic [15:0] exp;
    int cyc;
    bit busy_ok;
    exp = ref_mul(a, b);
    chk("ready_before", {15'd0, in_ready}, 16'd1);
    in_valid  = 1'b1;
    x         = a;
    y         = b;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 20) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      if (scramble) begin
        x        = 8'($urandom);
        y        = 8'($urandom);
        in_valid = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", 16'(cyc), 16'd8);
    chk("busy_calc", {15'd0, busy_ok}, 16'd1);
    chk("product", product, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      x        = 8'($urandom);
      @(negedge clk);
      chk("stall_valid", {15'd0, out_valid}, 16'd1);
      chk("stall_prod", product, exp);
      chk("stall_busy", {15'd0, in_ready}, 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ready_after", {15'd0, in_ready}, 16'd1);
    chk("valid_after", {15'd0, out_valid}, 16'd0);
    chk("prod_kept", product, exp);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 8'h00;
    y         = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_prod", product, 16'h0000);

    run_op(8'h00, 8'h00, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 0, 1'b0);
    run_op(8'h01, 8'hFF, 0, 1'b0);
    run_op(8'h10, 8'h10, 0, 1'b0);
    run_op(8'h80, 8'h02, 0, 1'b0);
    run_op(8'h03, 8'h05, 0, 1'b0);
    run_op(8'h0D, 8'h0B, 5, 1'b0);

    // Abort on the 4th CALC cycle.
    in_valid = 1'b1;
    x        = 8'hAA;
    y        = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {15'd0, in_ready}, 16'd1);
    chk("abort_valid", {15'd0, out_valid}, 16'd0);
    chk("abort_prod", product, 16'h0000);
    repeat (10) @(negedge clk);
    chk("abort_quiet", {15'd0, out_valid}, 16'd0);
    run_op(8'h02, 8'h03, 0, 1'b0);

    run_op(8'h07, 8'h09, 1, 1'b1);

    for (int n = 0; n < 25; n++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
